// File: rtl/fmem_write_ctrl_if.sv
// Bus bundle between the video input and the frame-memory write port.
// The master modport is the video source / memory observer, the slave modport is the controller.
interface fmem_write_ctrl_if #(
  parameter int DATA_WIDTH   = 24,
  parameter int PIX_PER_WORD = 4,
  parameter int ADDR_WIDTH   = 16
);
  localparam int MEM_WIDTH = DATA_WIDTH * PIX_PER_WORD;

  logic                  i_vsync;
  logic                  i_de;
  logic [DATA_WIDTH-1:0] i_data;
  logic [10:0]           i_vres;

  logic                  fmem_csn;
  logic                  fmem_wen;
  logic [ADDR_WIDTH-1:0] fmem_addr;
  logic [MEM_WIDTH-1:0]  fmem_din;
  logic                  o_frame_done;
  logic                  o_overflow;

  modport master (
    output i_vsync, i_de, i_data, i_vres,
    input  fmem_csn, fmem_wen, fmem_addr, fmem_din, o_frame_done, o_overflow
  );

  modport slave (
    input  i_vsync, i_de, i_data, i_vres,
    output fmem_csn, fmem_wen, fmem_addr, fmem_din, o_frame_done, o_overflow
  );
endinterface

// File: rtl/fmem_write_ctrl.sv
// Frame-memory write controller: packs DE-qualified pixels into memory words and
// issues single-cycle active-low write strobes at linear addresses from 0 per frame.
//
// state  | meaning
// IDLE   | after reset, waiting for the first vsync rise; DE ignored
// ACTIVE | capturing lines of the current frame
// DONE   | last line of the frame written; DE ignored until the next vsync rise
module fmem_write_ctrl #(
  parameter int DATA_WIDTH   = 24,
  parameter int PIX_PER_WORD = 4,
  parameter int MEM_WIDTH    = DATA_WIDTH * PIX_PER_WORD,
  parameter int ADDR_DEPTH   = 512 * 512 / 4,
  parameter int ADDR_WIDTH   = $clog2(ADDR_DEPTH)
) (
  input logic              i_clk,
  input logic              rst,
  fmem_write_ctrl_if.slave bus
);

  localparam int PCW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [PCW-1:0] LAST_LANE = PCW'(PIX_PER_WORD - 1);
  // The address counter has one extra bit so it can sit at ADDR_DEPTH (saturated)
  // without wrapping back onto valid locations.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(ADDR_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state;
  logic                 vsync_q;
  logic                 de_q;
  logic [PCW-1:0]       pack_cnt;
  logic [10:0]          line_cnt;
  logic [ADDR_WIDTH:0]  addr_cnt;
  logic [MEM_WIDTH-1:0] word_buf;
  logic [MEM_WIDTH-1:0] word_nxt;
  logic [MEM_WIDTH-1:0] wr_data;
  logic [10:0]          line_nxt;
  logic                 frame_start;
  logic                 line_end;
  logic                 wr_req;

  assign frame_start = bus.i_vsync & ~vsync_q;
  assign line_end    = de_q & ~bus.i_de;
  assign line_nxt    = line_cnt + 11'd1;

  // Word as it would look with the current pixel dropped into its lane; unused
  // upper lanes stay zero because word_buf is cleared after every write.
  always_comb begin
    word_nxt = word_buf;
    word_nxt[int'(pack_cnt) * DATA_WIDTH +: DATA_WIDTH] = bus.i_data;
  end

  // A write is due when a word fills up, or at end of line with a partial word;
  // a frame start in the same cycle discards both.
  always_comb begin
    wr_req  = 1'b0;
    wr_data = word_buf;
    if (state == ACTIVE && !frame_start) begin
      if (bus.i_de && pack_cnt == LAST_LANE) begin
        wr_req  = 1'b1;
        wr_data = word_nxt;
      end else if (line_end && pack_cnt != '0) begin
        wr_req  = 1'b1;
        wr_data = word_buf;
      end
    end
  end

  // Sequencing FSM with registered memory-port and status outputs.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      vsync_q          <= 1'b0;
      de_q             <= 1'b0;
      pack_cnt         <= '0;
      line_cnt         <= '0;
      addr_cnt         <= '0;
      word_buf         <= '0;
      bus.fmem_csn     <= 1'b1;
      bus.fmem_wen     <= 1'b1;
      bus.fmem_addr    <= '0;
      bus.fmem_din     <= '0;
      bus.o_frame_done <= 1'b0;
      bus.o_overflow   <= 1'b0;
    end else begin
      vsync_q          <= bus.i_vsync;
      de_q             <= bus.i_de;
      bus.fmem_csn     <= 1'b1;
      bus.fmem_wen     <= 1'b1;
      bus.o_frame_done <= 1'b0;

      if (frame_start) begin
        state          <= ACTIVE;
        pack_cnt       <= '0;
        line_cnt       <= '0;
        addr_cnt       <= '0;
        word_buf       <= '0;
        bus.o_overflow <= 1'b0;
      end else if (state == ACTIVE) begin
        if (wr_req) begin
          if (addr_cnt < ADDR_LIMIT) begin
            bus.fmem_csn  <= 1'b0;
            bus.fmem_wen  <= 1'b0;
            bus.fmem_addr <= addr_cnt[ADDR_WIDTH-1:0];
            bus.fmem_din  <= wr_data;
            addr_cnt      <= addr_cnt + 1'b1;
          end else begin
            bus.o_overflow <= 1'b1;
          end
          word_buf <= '0;
          pack_cnt <= '0;
        end else if (bus.i_de) begin
          word_buf <= word_nxt;
          pack_cnt <= pack_cnt + 1'b1;
        end

        if (line_end) begin
          line_cnt <= line_nxt;
          if (line_nxt == bus.i_vres) begin
            state            <= DONE;
            bus.o_frame_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fmem_write_ctrl.sv
// Bench for fmem_write_ctrl: two instances (roomy and 4-word memory) share one
// randomized pixel stream; a frame-level model predicts every write/done event
// into per-instance queues, and negedge monitors pop and compare.
module tb_fmem_write_ctrl;
  localparam int DW      = 24;
  localparam int PPW     = 4;
  localparam int MW      = DW * PPW;
  localparam int DEPTH_A = 32;
  localparam int DEPTH_B = 4;
  localparam int AW_A    = $clog2(DEPTH_A);
  localparam int AW_B    = $clog2(DEPTH_B);

  typedef struct {
    int            cy;
    bit            stb;
    int            addr;
    logic [MW-1:0] din;
    bit            done;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  fmem_write_ctrl_if #(.DATA_WIDTH(DW), .PIX_PER_WORD(PPW), .ADDR_WIDTH(AW_A)) ifa ();
  fmem_write_ctrl_if #(.DATA_WIDTH(DW), .PIX_PER_WORD(PPW), .ADDR_WIDTH(AW_B)) ifb ();

  fmem_write_ctrl #(.DATA_WIDTH(DW), .PIX_PER_WORD(PPW), .ADDR_DEPTH(DEPTH_A), .ADDR_WIDTH(AW_A))
    dut_a (.i_clk(clk), .rst(rst), .bus(ifa));
  fmem_write_ctrl #(.DATA_WIDTH(DW), .PIX_PER_WORD(PPW), .ADDR_DEPTH(DEPTH_B), .ADDR_WIDTH(AW_B))
    dut_b (.i_clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  ev_t         qa[$];
  ev_t         qb[$];
  logic [DW-1:0] pend[$];
  int          m_addr[2];
  bit          m_ovf[2];
  bit          armed;
  int          lines;
  int          vres;
  bit          prev_de;
  int          depth[2] = '{DEPTH_A, DEPTH_B};

  task automatic push_ev(input int k, input ev_t e);
    if (k == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // One memory word from the pending pixels, pixel 0 in the LSBs, missing lanes zero.
  task automatic emit_word(input int cy, input bit done);
    logic [MW-1:0] w;
    ev_t e;
    w = '0;
    for (int i = 0; i < pend.size(); i++) w[i*DW +: DW] = pend[i];
    pend.delete();
    for (int k = 0; k < 2; k++) begin
      if (m_addr[k] < depth[k]) begin
        e = '{cy: cy, stb: 1'b1, addr: m_addr[k], din: w, done: done};
        m_addr[k]++;
        push_ev(k, e);
      end else begin
        m_ovf[k] = 1'b1;
        if (done) begin
          e = '{cy: cy, stb: 1'b0, addr: 0, din: '0, done: 1'b1};
          push_ev(k, e);
        end
      end
    end
  endtask

  task automatic model_pixel(input logic [DW-1:0] p, input int c);
    if (!armed) return;
    pend.push_back(p);
    if (pend.size() == PPW) emit_word(c + 1, 1'b0);
  endtask

  task automatic model_fall(input int c);
    bit last;
    ev_t e;
    if (!armed) return;
    lines++;
    last = (lines == vres);
    if (pend.size() > 0) emit_word(c + 1, last);
    else if (last) begin
      e = '{cy: c + 1, stb: 1'b0, addr: 0, din: '0, done: 1'b1};
      push_ev(0, e);
      push_ev(1, e);
    end
    if (last) armed = 1'b0;
  endtask

  task automatic model_frame_start();
    pend.delete();
    m_addr = '{0, 0};
    m_ovf  = '{1'b0, 1'b0};
    lines  = 0;
    armed  = 1'b1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic vs, input logic de, input logic [DW-1:0] d);
    ifa.i_vsync = vs; ifb.i_vsync = vs;
    ifa.i_de    = de; ifb.i_de    = de;
    ifa.i_data  = d;  ifb.i_data  = d;
  endtask

  task automatic set_vres(input int v);
    vres = v;
    ifa.i_vres = 11'(v);
    ifb.i_vres = 11'(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [DW-1:0] p);
    set_in(1'b0, 1'b1, p);
    model_pixel(p, cyc);
    prev_de = 1'b1;
    tick();
  endtask

  task automatic rand_pixel();
    logic [DW-1:0] p;
    p = DW'($urandom());
    pixel(p);
  endtask

  task automatic de_low(input int n);
    logic [DW-1:0] junk;
    for (int i = 0; i < n; i++) begin
      junk = DW'($urandom());
      set_in(1'b0, 1'b0, junk);
      if (prev_de) model_fall(cyc);
      prev_de = 1'b0;
      tick();
    end
  endtask

  // A vsync rise; if DE was high the previous cycle this is also a DE fall, which the frame start overrides.
  task automatic vs_pulse();
    set_in(1'b1, 1'b0, '0);
    model_frame_start();
    prev_de = 1'b0;
    tick();
    set_in(1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic rand_line(input int h, input int gap);
    for (int i = 0; i < h; i++) rand_pixel();
    de_low(gap);
  endtask

  // ---------------- checks ----------------
  task automatic check_ev(input string tag, input ev_t e, input int c, input logic csn,
                          input logic wen, input int addr, input logic [MW-1:0] din, input logic done);
    bit ok;
    logic exp_n;
    exp_n = ~e.stb;
    ok = (c == e.cy) && (csn === exp_n) && (wen === exp_n) && (done === e.done);
    if (e.stb) ok = ok && (addr == e.addr) && (din === e.din);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_event: got cyc=%0d csn=%b wen=%b addr=%0d din=%h done=%b ; want cyc=%0d strobe=%b addr=%0d din=%h done=%b",
               tag, c, csn, wen, addr, din, done, e.cy, e.stb, e.addr, e.din, e.done);
    end
  endtask

  task automatic unexpected(input string tag, input logic csn, input logic done);
    total++;
    bad++;
    $display("FAIL %s_unexpected: cyc=%0d csn=%b done=%b with nothing expected", tag, cyc, csn, done);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && (ifa.fmem_csn === 1'b0 || ifa.fmem_wen === 1'b0 || ifa.o_frame_done === 1'b1)) begin
      if (qa.size() == 0) unexpected("A", ifa.fmem_csn, ifa.o_frame_done);
      else check_ev("A", qa.pop_front(), cyc, ifa.fmem_csn, ifa.fmem_wen, int'(ifa.fmem_addr), ifa.fmem_din, ifa.o_frame_done);
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && (ifb.fmem_csn === 1'b0 || ifb.fmem_wen === 1'b0 || ifb.o_frame_done === 1'b1)) begin
      if (qb.size() == 0) unexpected("B", ifb.fmem_csn, ifb.o_frame_done);
      else check_ev("B", qb.pop_front(), cyc, ifb.fmem_csn, ifb.fmem_wen, int'(ifb.fmem_addr), ifb.fmem_din, ifb.o_frame_done);
    end
  end

  task automatic chk_rst(input string tag, input logic csn, input logic wen, input int addr,
                         input logic [MW-1:0] din, input logic done, input logic ovf);
    total++;
    if (csn !== 1'b1 || wen !== 1'b1 || addr != 0 || din !== '0 || done !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL %s_reset: got csn=%b wen=%b addr=%0d din=%h done=%b ovf=%b ; want 1 1 0 0 0 0",
               tag, csn, wen, addr, din, done, ovf);
    end
  endtask

  task automatic chk_reset_both();
    chk_rst("A", ifa.fmem_csn, ifa.fmem_wen, int'(ifa.fmem_addr), ifa.fmem_din, ifa.o_frame_done, ifa.o_overflow);
    chk_rst("B", ifb.fmem_csn, ifb.fmem_wen, int'(ifb.fmem_addr), ifb.fmem_din, ifb.o_frame_done, ifb.o_overflow);
  endtask

  task automatic chk_ovf(input string tag);
    total++;
    if (ifa.o_overflow !== m_ovf[0]) begin
      bad++;
      $display("FAIL %s_overflow_A: got %b want %b", tag, ifa.o_overflow, m_ovf[0]);
    end
    total++;
    if (ifb.o_overflow !== m_ovf[1]) begin
      bad++;
      $display("FAIL %s_overflow_B: got %b want %b", tag, ifb.o_overflow, m_ovf[1]);
    end
  endtask

  task automatic chk_drained(input string tag);
    total++;
    if (qa.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_A: %0d expected events never seen", tag, qa.size());
      qa.delete();
    end
    total++;
    if (qb.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_B: %0d expected events never seen", tag, qb.size());
      qb.delete();
    end
  endtask

  // Hard stop in case stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int v, h, nl;
    bit abort;
    cyc = 0; total = 0; bad = 0;
    armed = 1'b0; lines = 0; prev_de = 1'b0;
    m_addr = '{0, 0};
    m_ovf  = '{1'b0, 1'b0};
    rst = 1'b1;
    set_in(1'b0, 1'b0, '0);
    set_vres(2);
    repeat (3) tick();
    chk_reset_both();
    rst = 1'b0;
    repeat (2) tick();
    chk_reset_both();

    // Before any vsync the block is idle: a line of DE is ignored.
    rand_line(8, 3);
    chk_drained("idle");

    // Two lines of 1..8.
    set_vres(2);
    vs_pulse();
    for (int l = 0; l < 2; l++) begin
      for (int i = 1; i <= 8; i++) pixel(DW'(i));
      de_low(3);
    end
    de_low(3);
    chk_drained("t1");
    chk_ovf("t1");

    // Six pixels, partial word flushed on DE fall.
    set_vres(1);
    vs_pulse();
    rand_line(6, 4);
    chk_drained("t2");

    // Frame start after three pixels (DE falls in the vsync cycle): partial word dropped.
    set_vres(2);
    vs_pulse();
    for (int i = 0; i < 3; i++) rand_pixel();
    vs_pulse();
    rand_line(4, 2);
    rand_line(5, 3);
    chk_drained("t3");
    chk_ovf("t3");

    // 20 pixels on one line: the 4-word instance drops word 5 and flags overflow.
    set_vres(1);
    vs_pulse();
    rand_line(20, 3);
    chk_drained("t4");
    chk_ovf("t4");
    de_low(10);
    chk_ovf("t4_sticky");

    // Block is in DONE: 16 pixels produce nothing.
    rand_line(8, 2);
    rand_line(8, 2);
    chk_drained("t5_done");
    vs_pulse();
    chk_ovf("t4_clear");
    rand_line(4, 3);
    chk_drained("t5_rearm");

    // Reset during the second pixel of a word.
    set_vres(1);
    vs_pulse();
    rand_pixel();
    set_in(1'b0, 1'b1, DW'($urandom()));
    rst = 1'b1;
    #1;
    chk_reset_both();
    pend.delete();
    armed = 1'b0;
    m_addr = '{0, 0};
    m_ovf  = '{1'b0, 1'b0};
    prev_de = 1'b0;
    tick();
    set_in(1'b0, 1'b0, '0);
    tick();
    rst = 1'b0;
    tick();
    chk_reset_both();
    vs_pulse();
    rand_line(7, 3);
    chk_drained("t6");

    // Randomized frames, sometimes aborted mid-line, sometimes with ignored trailing lines.
    for (int f = 0; f < 30; f++) begin
      v = $urandom_range(1, 3);
      set_vres(v);
      vs_pulse();
      abort = ($urandom_range(0, 5) == 0);
      nl = v + $urandom_range(0, 1);
      for (int l = 0; l < nl; l++) begin
        h = $urandom_range(1, 13);
        if (abort && l == nl - 1) begin
          for (int i = 0; i < h; i++) rand_pixel();
        end else begin
          rand_line(h, $urandom_range(1, 3));
        end
      end
      if (!abort) begin
        de_low(3);
        chk_drained("rand");
        chk_ovf("rand");
      end
    end
    vs_pulse();
    de_low(5);
    chk_drained("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
